axis_pixel_transmitter: RTL and testbench

- Output end of the 5x5 median pipeline: accepts the filtered pixel stream (data/valid/start-of-frame, no backpressure) and presents it as an AXI4-Stream video master (tdata/tvalid/tready/tuser/tlast).
- Buffers pixels in a FIFO to absorb downstream stalls.
- Regenerates tuser (SOF) and tlast (end of line) from its own column counter.
- Flags dropped pixels.

---
 rtl/axis_pixel_transmitter.sv | 107 ++++++++++
 tb/tb_axis_pixel_transmitter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/axis_pixel_transmitter.sv
// axis_pixel_transmitter
//   Output end of the median pipeline. Takes the filtered pixel stream (no
//   backpressure upstream), buffers it in a circular FIFO and presents it as
//   an AXI4-Stream video master. tuser (start of frame) and tlast (end of
//   line) are regenerated from a local column counter. Pixels that arrive
//   while the buffer is full are dropped and flagged on a sticky bit.
//
// Ports
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_data/_valid         filtered pixel and its qualifier
//   i_start_of_frame      marks a valid pixel as the first of a frame
//   m_axis_t*             AXI4-Stream master (tdata/tvalid/tready/tuser/tlast)
//   o_fifo_level          buffered entries, including the output-stage beat
//   o_overflow            sticky: a valid pixel was dropped
module axis_pixel_transmitter #(
  parameter int DATA_WIDTH  = 8,
  parameter int IMAGE_WIDTH = 10,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_data_valid,
  input  logic                          i_start_of_frame,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

  typedef struct packed {
    logic                  sof;
    logic                  eol;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  entry_t          wr_ent, out_ent;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic [CW-1:0]   col_cnt, col;
  logic            out_vld, ovf;
  logic            pop, push, ram_empty, load;

  always_comb begin
    pop       = out_vld & m_axis_tready;
    // Full with a simultaneous pop still has room: the pop frees a slot.
    push      = i_data_valid & ((level < LW'(FIFO_DEPTH)) | pop);
    // level covers RAM plus the output stage; RAM is empty when only the
    // output stage (if any) holds data.
    ram_empty = (level == LW'(out_vld));
    // Refill the output stage whenever it is empty or being drained.
    load      = ~ram_empty & (~out_vld | pop);

    col         = i_start_of_frame ? '0 : col_cnt;
    wr_ent.sof  = i_start_of_frame;
    wr_ent.eol  = (col == CW'(IMAGE_WIDTH - 1));
    wr_ent.data = i_data;
  end

  // Storage array, no reset needed: contents are qualified by the pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= wr_ent;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      col_cnt <= '0;
      out_vld <= 1'b0;
      out_ent <= '0;
      ovf     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) begin
        rd_ptr  <= rd_ptr + 1'b1;
        out_ent <= mem[rd_ptr];
      end
      out_vld <= load | (out_vld & ~pop);
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      // Dropped pixels still advance the column so later tags stay aligned.
      if (i_data_valid) col_cnt <= wr_ent.eol ? '0 : col + 1'b1;
      if (i_data_valid & ~push) ovf <= 1'b1;
    end
  end

  assign m_axis_tdata  = out_ent.data;
  assign m_axis_tuser  = out_ent.sof;
  assign m_axis_tlast  = out_ent.eol;
  assign m_axis_tvalid = out_vld;
  assign o_fifo_level  = level;
  assign o_overflow    = ovf;

endmodule

// File: tb/tb_axis_pixel_transmitter.sv
module tb_axis_pixel_transmitter;
  localparam int DW = 8, IW = 10, FD = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1, valid = 1'b0, sof = 1'b0, tready = 1'b0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] tdata;
  logic          tvalid, tuser, tlast, ovf;
  logic [4:0]    level;

  int checks = 0, failures = 0;
  logic chk_en = 1'b0;

  axis_pixel_transmitter #(.DATA_WIDTH(DW), .IMAGE_WIDTH(IW), .FIFO_DEPTH(FD)) dut (
    .i_clk(clk), .i_reset(rst), .i_data(data), .i_data_valid(valid),
    .i_start_of_frame(sof), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .m_axis_tuser(tuser), .m_axis_tlast(tlast),
    .o_fifo_level(level), .o_overflow(ovf));

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Model: a queue of accepted beats. A beat can be presented once the edge
  // after its acceptance has passed and it is at the head of the queue.
  typedef struct {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
    int            e;
  } ment_t;
  ment_t mq[$];
  int    now = 0, mcol = 0;
  logic  movf = 1'b0;
  logic [9:0] beats[$];

  always @(posedge clk) begin
    int c; logic eol, mpop, mpush;
    if (rst) begin
      mq.delete(); mcol = 0; movf = 1'b0;
    end else begin
      mpop  = (mq.size() > 0) && (mq[0].e < now) && tready;
      mpush = valid && ((mq.size() < FD) || mpop);
      eol = 1'b0;
      if (valid) begin
        c    = sof ? 0 : mcol;
        eol  = (c == IW - 1);
        mcol = eol ? 0 : c + 1;
      end
      if (mpop) void'(mq.pop_front());
      if (mpush) mq.push_back('{data, sof, eol, now + 1});
      if (valid && !mpush) movf = 1'b1;
    end
    now++;
  end

  always @(negedge clk) begin
    logic exp_v;
    if (chk_en) begin
      exp_v = (mq.size() > 0) && (mq[0].e < now);
      chk("tvalid", int'(tvalid), int'(exp_v));
      if (exp_v) chk("beat", int'({tdata, tuser, tlast}), int'({mq[0].d, mq[0].u, mq[0].l}));
      chk("level", int'(level), mq.size());
      chk("overflow", int'(ovf), int'(movf));
      if (tvalid && tready) beats.push_back({tdata, tuser, tlast});
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic px(input logic s, input int d);
    valid = 1'b1; sof = s; data = DW'(d);
    tick();
    valid = 1'b0; sof = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    beats.delete();
  endtask

  task automatic drain();
    int n = 0;
    tready = 1'b1;
    while (mq.size() > 0 && n < 500) begin tick(); n++; end
    chk("drain_timeout", int'(n < 500), 1);
    tick();
  endtask

  task automatic chk_beats(input string nm, input int n, input int first, input int last_at);
    chk({nm, "_count"}, beats.size(), n);
    for (int i = 0; i < beats.size() && i < n; i++)
      chk(nm, int'(beats[i]), int'({DW'(first + i), 1'(i == 0), 1'(i == last_at)}));
  endtask

  initial begin
    do_reset();
    chk_en = 1'b1;
    // reset state
    chk("rst_tvalid", int'(tvalid), 0);
    chk("rst_tdata", int'(tdata), 0);
    chk("rst_tuser_tlast", int'({tuser, tlast}), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf", int'(ovf), 0);

    // 1: one line streaming, tready high
    tready = 1'b1;
    px(1'b1, 1);
    chk("lat_before", int'(tvalid), 0);
    px(1'b0, 2);
    chk("lat_after", int'(tvalid), 1);
    for (int i = 3; i <= 10; i++) px(1'b0, i);
    drain();
    chk_beats("t1", 10, 1, 9);
    chk("t1_ovf", int'(ovf), 0);

    // 2: stall for the first 8 pixels
    do_reset();
    tready = 1'b0;
    for (int i = 1; i <= 8; i++) px(i == 1, i);
    chk("t2_level8", int'(level), 8);
    tready = 1'b1;
    px(1'b0, 9); px(1'b0, 10);
    drain();
    chk_beats("t2", 10, 1, 9);

    // 3: overflow, 20 pixels into a stalled FIFO
    do_reset();
    tready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      px(i == 1, i);
      if (i == 16) begin
        chk("t3_level16", int'(level), 16);
        chk("t3_ovf_pre", int'(ovf), 0);
      end
      if (i == 17) chk("t3_ovf_rise", int'(ovf), 1);
    end
    chk("t3_level_sat", int'(level), 16);
    drain();
    chk_beats("t3", 16, 1, 9);
    chk("t3_ovf_sticky", int'(ovf), 1);

    // 4: full FIFO with simultaneous push and pop
    do_reset();
    tready = 1'b0;
    for (int i = 1; i <= 16; i++) px(i == 1, i);
    chk("t4_full", int'(level), 16);
    tready = 1'b1;
    px(1'b0, 17);
    chk("t4_level", int'(level), 16);
    chk("t4_ovf", int'(ovf), 0);
    drain();
    chk_beats("t4", 17, 1, 9);

    // 5: SOF re-asserted at pixel 4
    do_reset();
    tready = 1'b1;
    for (int i = 1; i <= 13; i++) px(i == 1 || i == 4, i);
    drain();
    chk("t5_count", beats.size(), 13);
    for (int i = 0; i < beats.size() && i < 13; i++)
      chk("t5", int'(beats[i]), int'({DW'(i + 1), 1'(i == 0 || i == 3), 1'(i == 12)}));

    // 6: reset with beats buffered, then a clean frame
    do_reset();
    tready = 1'b0;
    for (int i = 1; i <= 5; i++) px(i == 1, 50 + i);
    tick();
    chk("t6_pre_tvalid", int'(tvalid), 1);
    chk("t6_pre_level", int'(level), 5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_tvalid", int'(tvalid), 0);
    chk("t6_level", int'(level), 0);
    chk("t6_tdata", int'({tdata, tuser, tlast}), 0);
    beats.delete();
    tready = 1'b1;
    for (int i = 1; i <= 10; i++) px(i == 1, i);
    drain();
    chk_beats("t6", 10, 1, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
